pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Interlock and forwarding controller for the 5-stage CPU pipeline.
- Tracks in-flight destination registers internally through EX and MEM.
- Drives operand-forwarding selects for the ID stage.
- Stalls IF/ID on load-use hazards and while the multi-cycle MDU occupies EX.
- Flushes the fetched instruction after a taken branch or jump resolved in ID.

Sits beside ID_STAGE; its stall, bubble and flush outputs gate the PC and the IF/ID and ID/EX pipeline registers.

## Interface
- MDU_LAT, 4: EX occupancy in cycles of a multi-cycle (mul/div) instruction; legal range 2..15.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- id_valid  in  1  ID holds a real (non-bubble) instruction.
- id_rs, id_rt  in  5 each  source register numbers in ID.
- id_use_rs, id_use_rt  in  1 each  instruction actually reads rs / rt.
- id_wreg  in  1  ID instruction writes the register file.
- id_m2reg  in  1  ID instruction is a load.
- id_rn  in  5  ID destination register.
- id_mdu  in  1  ID instruction is a multi-cycle MDU op.
- id_pcsource  in  2  next-PC select from control unit; nonzero = redirect.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  load a NOP into ID/EX.
- ex_hold  out  1  hold ID/EX contents (MDU busy).
- flush  out  1  replace IF/ID with NOP at next edge.
- fwda, fwdb  out  2 each  operand select: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.

## Operation
- Scoreboard entries EX and MEM each hold {v, wreg, m2reg, rn}.
- Entry match: v & wreg & rn == src & src != 0 & the corresponding id_use_*.
- Register 0 never matches.
- Issue occurs when id_valid & ~stall. On issue, the ID fields load into EX; otherwise EX loads v=0.
- EX advances to MEM every cycle except while ex_hold=1. During ex_hold, MEM loads v=0.
- FSM states:
  - RUN: normal operation.
  - MDU_BUSY: counter cnt, width 4.
- RUN to MDU_BUSY when an id_mdu instruction issues; cnt loads MDU_LAT-1.
- In MDU_BUSY, cnt decrements each cycle. Exit to RUN on the edge where cnt==1.
- In MDU_BUSY:
  - stall=1, ex_hold=1, bubble=0, flush=0.
  - Forwarding is still computed.
- Load-use hazard (RUN only): an EX entry matches rs or rt with m2reg=1. Response: stall=1, bubble=1 for one cycle. The next cycle the load is in MEM and is forwarded with 11.
- Forward priority:
  - EX match, non-load: 01.
  - Else MEM match: 11 if m2reg, else 10.
  - Else 00.
- A write completing in the same cycle from WB is covered by the regfile's write-before-read. This block does not handle it.
- flush = id_valid & (id_pcsource != 0) & ~stall. A redirecting branch waiting on a load-use hazard flushes only on the cycle it issues.
- Priority: rst > MDU_BUSY > load-use > flush.

## Timing
- Reset values:
  - All entries v=0, state RUN, cnt=0.
  - Outputs: stall=0, bubble=0, ex_hold=0, flush=0, fwda=fwdb=00.
- stall, bubble, flush, fwda and fwdb are combinational from registered state and current ID inputs, valid in the same cycle.
- ex_hold is a function of registered state only.
- Load-use costs exactly 1 stall cycle.
- An MDU op costs MDU_LAT-1 stall cycles after its issue cycle.
- Reset asserted mid-MDU_BUSY: the next cycle is RUN with cnt=0 and all entries empty. Any instruction held in ID is re-evaluated from scratch.
- Back-to-back MDU ops: the second issues in the first RUN cycle after the first op and re-enters MDU_BUSY.

## Structure
- Package pipe_pkg:
  - FWD_REG/FWD_EXALU/FWD_MEMALU/FWD_MEMLD encodings.
  - FSM state typedef (RUN, MDU_BUSY).
  - Scoreboard entry struct.
  - MDU_LAT default.
- One sub-module, hazard_scoreboard, holds the EX/MEM entries with issue/hold/advance control and exports match flags per source.
- FSM, counter and output logic stay in pipe_hazard_ctrl.

## Test plan
- Independent ALU ops (add r3,r1,r2; add r5,r4,r6):
  - stall=0, fwda=fwdb=00 throughout.
- add r3,r1,r2 then sub r4,r3,r3:
  - Second op in ID: fwda=fwdb=01, no stall.
  - With one NOP between: fwda=fwdb=10.
- lw r2,0(r1) then add r4,r2,r5:
  - One cycle with stall=1, bubble=1.
  - Next cycle: fwda=11, stall=0.
- MDU op with MDU_LAT=4 followed by a dependent add:
  - stall=ex_hold=1 for 3 cycles after issue, then RUN.
  - Add forwards 01 from EX.
- Taken beq (id_pcsource=01) with no hazard:
  - flush=1 for one cycle.
  - Same beq depending on a prior lw: flush=0 during the stall cycle, flush=1 on the following cycle.
- rst pulsed on the second cycle of MDU_BUSY:
  - Next cycle stall=0, ex_hold=0, fwda=fwdb=00.
  - Writes to r0 never produce a forward or a stall.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and encodings for the pipeline hazard/forwarding controller.
package pipe_pkg;

  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_EXALU  = 2'b01;
  localparam logic [1:0] FWD_MEMALU = 2'b10;
  localparam logic [1:0] FWD_MEMLD  = 2'b11;

  localparam int unsigned MDU_LAT_DEFAULT = 4;

  typedef enum logic [0:0] {
    RUN,
    MDU_BUSY
  } state_e;

  typedef struct packed {
    logic       v;
    logic       wreg;
    logic       m2reg;
    logic [4:0] rn;
  } sb_entry_t;

  // EX ALU results win over anything in MEM; an EX load cannot be forwarded yet.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic ex_ld,
                                         input logic mem_hit, input logic mem_ld);
    logic [1:0] sel;
    sel = FWD_REG;
    if (ex_hit && !ex_ld) begin
      sel = FWD_EXALU;
    end else if (mem_hit) begin
      sel = mem_ld ? FWD_MEMLD : FWD_MEMALU;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage <-> hazard controller signal bundle.
interface pipe_hazard_ctrl_if;

  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_wreg;
  logic       id_m2reg;
  logic [4:0] id_rn;
  logic       id_mdu;
  logic [1:0] id_pcsource;

  logic       stall;
  logic       bubble;
  logic       ex_hold;
  logic       flush;
  logic [1:0] fwda;
  logic [1:0] fwdb;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_rn,
           id_mdu, id_pcsource,
    input  stall, bubble, ex_hold, flush, fwda, fwdb
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_rn,
           id_mdu, id_pcsource,
    output stall, bubble, ex_hold, flush, fwda, fwdb
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// EX/MEM destination-register scoreboard with per-source match flags.
module hazard_scoreboard
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       issue,
  input  logic       hold,
  input  logic       id_wreg,
  input  logic       id_m2reg,
  input  logic [4:0] id_rn,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  output logic       ex_hit_rs,
  output logic       ex_hit_rt,
  output logic       mem_hit_rs,
  output logic       mem_hit_rt,
  output logic       ex_m2reg,
  output logic       mem_m2reg
);

  sb_entry_t ex_q, ex_d;
  sb_entry_t mem_q, mem_d;

  function automatic logic entry_match(input sb_entry_t e, input logic [4:0] src,
                                       input logic use_src);
    return e.v && e.wreg && (e.rn == src) && (src != 5'd0) && use_src;
  endfunction

  always_comb begin
    ex_d  = ex_q;
    mem_d = '0;
    if (!hold) begin
      mem_d = ex_q;
      ex_d  = '0;
      if (issue) begin
        ex_d.v     = 1'b1;
        ex_d.wreg  = id_wreg;
        ex_d.m2reg = id_m2reg;
        ex_d.rn    = id_rn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
    end
  end

  always_comb begin
    ex_hit_rs  = entry_match(ex_q, id_rs, id_use_rs);
    ex_hit_rt  = entry_match(ex_q, id_rt, id_use_rt);
    mem_hit_rs = entry_match(mem_q, id_rs, id_use_rs);
    mem_hit_rt = entry_match(mem_q, id_rt, id_use_rt);
    ex_m2reg   = ex_q.m2reg;
    mem_m2reg  = mem_q.m2reg;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Interlock and forwarding controller for the 5-stage pipeline: load-use and
// MDU stalls, ID-resolved branch flush, and operand forwarding selects.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MDU_LAT = MDU_LAT_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic issue;
  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic ex_m2reg, mem_m2reg;
  logic load_use;
  logic busy;

  assign busy  = (state_q == MDU_BUSY);
  assign issue = bus.id_valid && !bus.stall;

  hazard_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .hold       (busy),
    .id_wreg    (bus.id_wreg),
    .id_m2reg   (bus.id_m2reg),
    .id_rn      (bus.id_rn),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_use_rs  (bus.id_use_rs),
    .id_use_rt  (bus.id_use_rt),
    .ex_hit_rs  (ex_hit_rs),
    .ex_hit_rt  (ex_hit_rt),
    .mem_hit_rs (mem_hit_rs),
    .mem_hit_rt (mem_hit_rt),
    .ex_m2reg   (ex_m2reg),
    .mem_m2reg  (mem_m2reg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (issue && bus.id_mdu) begin
          state_d = MDU_BUSY;
          cnt_d   = 4'(MDU_LAT - 1);
        end
      end
      MDU_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // An EX load can only be consumed from MEM, so it costs one stall cycle.
  assign load_use = (ex_hit_rs || ex_hit_rt) && ex_m2reg;

  always_comb begin
    bus.ex_hold = busy;
    bus.stall   = busy || load_use;
    bus.bubble  = !busy && load_use;
    bus.flush   = bus.id_valid && (bus.id_pcsource != 2'b00) && !bus.stall;
    bus.fwda    = fwd_sel(ex_hit_rs, ex_m2reg, mem_hit_rs, mem_m2reg);
    bus.fwdb    = fwd_sel(ex_hit_rt, ex_m2reg, mem_hit_rt, mem_m2reg);
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned LAT = 4;
  localparam int NUM_CYCLES = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MDU_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Reference model: each in-flight instruction is a record; busy_left counts
  // the remaining cycles the MDU op keeps EX occupied.
  typedef struct {
    bit v;
    bit wr;
    bit ld;
    int rn;
  } instr_t;

  instr_t in_ex, in_mem;
  int     busy_left;

  bit     m_stall, m_bubble, m_hold, m_flush;
  int     m_fwda, m_fwdb;

  function automatic bit reads(input instr_t e, input int src, input bit used);
    return e.v && e.wr && e.rn == src && src != 0 && used;
  endfunction

  function automatic int pick(input int src, input bit used);
    if (reads(in_ex, src, used) && !in_ex.ld) return 1;
    if (reads(in_mem, src, used)) return in_mem.ld ? 3 : 2;
    return 0;
  endfunction

  task automatic model_eval();
    bit lu;
    lu = in_ex.ld && (reads(in_ex, int'(bus.id_rs), bus.id_use_rs) ||
                      reads(in_ex, int'(bus.id_rt), bus.id_use_rt));
    m_hold   = busy_left > 0;
    m_stall  = m_hold || lu;
    m_bubble = !m_hold && lu;
    m_flush  = bus.id_valid && bus.id_pcsource != 0 && !m_stall;
    m_fwda   = pick(int'(bus.id_rs), bus.id_use_rs);
    m_fwdb   = pick(int'(bus.id_rt), bus.id_use_rt);
  endtask

  task automatic model_step();
    instr_t nop;
    nop = '{v: 0, wr: 0, ld: 0, rn: 0};
    if (rst) begin
      in_ex = nop;
      in_mem = nop;
      busy_left = 0;
    end else if (busy_left > 0) begin
      in_mem = nop;
      busy_left--;
    end else begin
      in_mem = in_ex;
      if (bus.id_valid && !m_stall) begin
        in_ex = '{v: 1, wr: bus.id_wreg, ld: bus.id_m2reg, rn: int'(bus.id_rn)};
        if (bus.id_mdu) busy_left = LAT - 1;
      end else begin
        in_ex = nop;
      end
    end
  endtask

  task automatic drive_random();
    bus.id_valid    = ($urandom_range(0, 7) != 0);
    bus.id_rs       = 5'($urandom_range(0, 3));
    bus.id_rt       = 5'($urandom_range(0, 3));
    bus.id_use_rs   = ($urandom_range(0, 3) != 0);
    bus.id_use_rt   = ($urandom_range(0, 3) != 0);
    bus.id_wreg     = ($urandom_range(0, 4) != 0);
    bus.id_m2reg    = ($urandom_range(0, 3) == 0);
    bus.id_rn       = 5'($urandom_range(0, 3));
    bus.id_mdu      = ($urandom_range(0, 9) == 0);
    bus.id_pcsource = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    rst             = ($urandom_range(0, 59) == 0);
  endtask

  task automatic compare_all();
    check("stall", {1'b0, bus.stall}, {1'b0, m_stall});
    check("bubble", {1'b0, bus.bubble}, {1'b0, m_bubble});
    check("ex_hold", {1'b0, bus.ex_hold}, {1'b0, m_hold});
    check("flush", {1'b0, bus.flush}, {1'b0, m_flush});
    check("fwda", bus.fwda, 2'(m_fwda));
    check("fwdb", bus.fwdb, 2'(m_fwdb));
  endtask

  initial begin
    bus.id_valid    = 1'b0;
    bus.id_rs       = 5'd0;
    bus.id_rt       = 5'd0;
    bus.id_use_rs   = 1'b0;
    bus.id_use_rt   = 1'b0;
    bus.id_wreg     = 1'b0;
    bus.id_m2reg    = 1'b0;
    bus.id_rn       = 5'd0;
    bus.id_mdu      = 1'b0;
    bus.id_pcsource = 2'b00;
    in_ex     = '{v: 0, wr: 0, ld: 0, rn: 0};
    in_mem    = '{v: 0, wr: 0, ld: 0, rn: 0};
    busy_left = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_stall", {1'b0, bus.stall}, 2'b00);
    check("reset_bubble", {1'b0, bus.bubble}, 2'b00);
    check("reset_ex_hold", {1'b0, bus.ex_hold}, 2'b00);
    check("reset_flush", {1'b0, bus.flush}, 2'b00);
    check("reset_fwda", bus.fwda, 2'b00);
    check("reset_fwdb", bus.fwdb, 2'b00);

    for (int i = 0; i < NUM_CYCLES; i++) begin
      @(negedge clk);
      cyc = i;
      drive_random();
      #1;
      model_eval();
      compare_all();
      @(posedge clk);
      model_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
